// File: rtl/seq1001_scan_ctrl.sv
// Word-level scan controller: serializes an accepted word MSB-first into a non-overlapping
// Moore "1001" detector and reports the saturating per-word detection count.
module seq1001_scan_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             carry_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             match_any_o,
  output logic             busy_o,
  output logic             det_hit_o
);

  localparam int unsigned BitCntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BitCntW-1:0] LastIdx = BitCntW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StReport
  } state_e;

  typedef enum logic [2:0] {
    DetS0,
    DetS1,
    DetS2,
    DetS3,
    DetS4
  } det_e;

  state_e             state_q, state_d;
  det_e               det_q, det_d, det_step;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic               feed_bit;

  assign feed_bit = shift_q[WIDTH-1];

  // Detector transition for the bit currently at the shift-register MSB.
  always_comb begin
    det_step = det_q;
    unique case (det_q)
      DetS0:   det_step = feed_bit ? DetS1 : DetS0;
      DetS1:   det_step = feed_bit ? DetS1 : DetS2;
      DetS2:   det_step = feed_bit ? DetS1 : DetS3;
      DetS3:   det_step = feed_bit ? DetS4 : DetS0;
      DetS4:   det_step = feed_bit ? DetS1 : DetS0;
      default: det_step = DetS0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    det_d       = det_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          shift_d   = in_data_i;
          bit_cnt_d = LastIdx;
          cnt_d     = '0;
          if (!carry_i) begin
            det_d = DetS0;
          end
          state_d = StShift;
        end
      end

      StShift: begin
        det_d   = det_step;
        shift_d = shift_q << 1;
        // Counting on entry to S4 credits a last-bit hit to the current word.
        if ((det_step == DetS4) && (cnt_q != CntMax)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (bit_cnt_q == '0) begin
          state_d = StReport;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end

      StReport: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      det_q     <= DetS0;
      cnt_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      det_q     <= det_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign match_cnt_o = cnt_q;
  assign match_any_o = (cnt_q != '0);
  assign busy_o      = (state_q != StIdle);
  assign det_hit_o   = (det_q == DetS4);

endmodule

// File: tb/tb_seq1001_scan_ctrl.sv
// Self-checking bench for seq1001_scan_ctrl: an 8-bit/4-bit-count instance and a
// 32-bit/2-bit-count instance, checked against a bit-history "1001" reference model.
module tb_seq1001_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        in_valid;
  logic [31:0] in_data;
  logic        carry;
  logic        out_ready;

  logic       ir8, ov8, any8, busy8, hit8;
  logic [3:0] cnt8;
  logic       ir32, ov32, any32, busy32, hit32;
  logic [1:0] cnt32;

  logic       cur_in_ready, cur_out_valid, cur_any, cur_busy, cur_hit;
  logic [3:0] cur_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state per instance: recent bits since the last match or restart.
  logic [3:0] m_win [2];
  int         m_len [2];
  logic       m_hit [2];

  always #5 clk = ~clk;

  seq1001_scan_ctrl #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid & ~sel),
    .in_ready_o (ir8),
    .in_data_i  (in_data[7:0]),
    .carry_i    (carry),
    .out_valid_o(ov8),
    .out_ready_i(out_ready & ~sel),
    .match_cnt_o(cnt8),
    .match_any_o(any8),
    .busy_o     (busy8),
    .det_hit_o  (hit8)
  );

  seq1001_scan_ctrl #(.WIDTH(32), .CNT_W(2)) u_dut32 (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid & sel),
    .in_ready_o (ir32),
    .in_data_i  (in_data),
    .carry_i    (carry),
    .out_valid_o(ov32),
    .out_ready_i(out_ready & sel),
    .match_cnt_o(cnt32),
    .match_any_o(any32),
    .busy_o     (busy32),
    .det_hit_o  (hit32)
  );

  assign cur_in_ready  = sel ? ir32 : ir8;
  assign cur_out_valid = sel ? ov32 : ov8;
  assign cur_cnt       = sel ? {2'b00, cnt32} : cnt8;
  assign cur_any       = sel ? any32 : any8;
  assign cur_busy      = sel ? busy32 : busy8;
  assign cur_hit       = sel ? hit32 : hit8;

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_win[k] = 4'b0000;
      m_len[k] = 0;
      m_hit[k] = 1'b0;
    end
  endtask

  // Non-overlapping count: a match is the last four bits since the previous match/restart
  // reading 1,0,0,1; the history restarts after each match.
  task automatic model_scan(input logic [31:0] data, input logic c,
                            output logic [3:0] cnt, output logic hit);
    int n;
    int w;
    int cmax;
    int s;
    s    = sel ? 1 : 0;
    w    = sel ? 32 : 8;
    cmax = sel ? 3 : 15;
    n    = 0;
    if (!c) begin
      m_win[s] = 4'b0000;
      m_len[s] = 0;
      m_hit[s] = 1'b0;
    end
    for (int i = w - 1; i >= 0; i--) begin
      m_win[s] = {m_win[s][2:0], data[i]};
      m_len[s] = m_len[s] + 1;
      m_hit[s] = 1'b0;
      if (m_len[s] >= 4 && m_win[s] == 4'b1001) begin
        n        = n + 1;
        m_hit[s] = 1'b1;
        m_len[s] = 0;
        m_win[s] = 4'b0000;
      end
    end
    cnt = (n > cmax) ? 4'(cmax) : 4'(n);
    hit = m_hit[s];
  endtask

  // Pushes one word through the selected instance and returns what it reported.
  task automatic do_word(input logic [31:0] data, input logic c, input int hold,
                         output int lat, output logic [3:0] cnt, output logic any,
                         output logic hit);
    int guard;
    guard = 0;
    lat   = -1;
    cnt   = 4'hx;
    any   = 1'bx;
    hit   = 1'bx;
    while (cur_in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (cur_in_ready !== 1'b1) return;
    in_valid = 1'b1;
    in_data  = data;
    carry    = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (cur_out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    cnt = cur_cnt;
    any = cur_any;
    hit = cur_hit;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({ir8, ov8, cnt8, any8, busy8, hit8} !== 9'b1_0_0000_0_0_0) begin
      miscompares++;
      $display("FAIL reset8: got %b expected %b", {ir8, ov8, cnt8, any8, busy8, hit8},
               9'b1_0_0000_0_0_0);
    end
    vectors++;
    if ({ir32, ov32, cnt32, any32, busy32, hit32} !== 7'b1_0_00_0_0_0) begin
      miscompares++;
      $display("FAIL reset32: got %b expected %b", {ir32, ov32, cnt32, any32, busy32, hit32},
               7'b1_0_00_0_0_0);
    end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_basic();
    int lat;
    logic [3:0] cnt, ecnt;
    logic any, hit, ehit;
    sel = 1'b0;
    model_scan(32'h99, 1'b0, ecnt, ehit);
    do_word(32'h99, 1'b0, 0, lat, cnt, any, hit);
    vectors++;
    if (lat != 8) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d expected 8", lat);
    end
    vectors++;
    if ({cnt, any, hit} !== {4'd2, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL basic_99: got cnt=%0d any=%b hit=%b expected cnt=2 any=1 hit=1",
               cnt, any, hit);
    end
    vectors++;
    if (cur_busy !== 1'b0 || cur_out_valid !== 1'b0 || cur_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_idle: got busy=%b ov=%b ir=%b expected 0 0 1",
               cur_busy, cur_out_valid, cur_in_ready);
    end
  endtask

  task automatic test_non_overlap();
    int lat;
    logic [3:0] cnt, ecnt;
    logic any, hit, ehit;
    sel = 1'b0;
    model_scan(32'h92, 1'b0, ecnt, ehit);
    do_word(32'h92, 1'b0, 1, lat, cnt, any, hit);
    vectors++;
    if ({cnt, any, hit} !== {4'd1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL non_overlap: got cnt=%0d any=%b hit=%b expected cnt=1 any=1 hit=0",
               cnt, any, hit);
    end
  endtask

  task automatic test_carry();
    int lat;
    logic [3:0] cnt, ecnt;
    logic any, hit, ehit;
    sel = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      model_scan(32'h04, 1'b0, ecnt, ehit);
      do_word(32'h04, 1'b0, 0, lat, cnt, any, hit);
      vectors++;
      if ({cnt, any} !== {4'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL carry_a%0d: got cnt=%0d any=%b expected cnt=0 any=0", pass, cnt, any);
      end
      model_scan(32'h80, (pass == 0), ecnt, ehit);
      do_word(32'h80, (pass == 0), 0, lat, cnt, any, hit);
      vectors++;
      if (cnt !== ((pass == 0) ? 4'd1 : 4'd0)) begin
        miscompares++;
        $display("FAIL carry_b%0d: got cnt=%0d expected %0d", pass, cnt,
                 (pass == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [3:0] cnt, ecnt;
    logic any, hit, ehit;
    sel = 1'b1;
    model_scan(32'h9999_9999, 1'b0, ecnt, ehit);
    do_word(32'h9999_9999, 1'b0, 0, lat, cnt, any, hit);
    vectors++;
    if (lat != 32) begin
      miscompares++;
      $display("FAIL sat_latency: got %0d expected 32", lat);
    end
    vectors++;
    if ({cnt, any, hit} !== {4'd3, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL saturation: got cnt=%0d any=%b hit=%b expected cnt=3 any=1 hit=1",
               cnt, any, hit);
    end
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [3:0] ecnt;
    logic ehit;
    logic [3:0] cnt;
    logic hit;
    sel = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h99;
    carry    = 1'b0;
    @(posedge clk); #1;
    model_scan(32'h99, 1'b0, ecnt, ehit);
    in_data = 32'h09;
    carry   = 1'b1;
    lat = 0;
    while (ov8 !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    cnt = cnt8;
    hit = hit8;
    vectors++;
    if (cnt !== 4'd2 || hit !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_first: got cnt=%0d hit=%b expected cnt=2 hit=1", cnt, hit);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({ov8, cnt8, hit8, ir8} !== {1'b1, 4'd2, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got ov=%b cnt=%0d hit=%b ir=%b expected 1 2 1 0",
                 i, ov8, cnt8, hit8, ir8);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if ({ir8, ov8, busy8} !== 3'b100) begin
      miscompares++;
      $display("FAIL bp_release: got ir=%b ov=%b busy=%b expected 1 0 0", ir8, ov8, busy8);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if ({ir8, busy8} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_accept: got ir=%b busy=%b expected 0 1", ir8, busy8);
    end
    model_scan(32'h09, 1'b1, ecnt, ehit);
    lat = 0;
    while (ov8 !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat != 8 || cnt8 !== 4'd1 || hit8 !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_second: got lat=%0d cnt=%0d hit=%b expected 8 1 1", lat, cnt8, hit8);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    logic [3:0] cnt, ecnt;
    logic any, hit, ehit;
    logic saw_valid;
    sel = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h99;
    carry    = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    vectors++;
    if ({ir8, ov8, cnt8, any8, busy8, hit8} !== 9'b1_0_0000_0_0_0) begin
      miscompares++;
      $display("FAIL rst_mid: got %b expected %b", {ir8, ov8, cnt8, any8, busy8, hit8},
               9'b1_0_0000_0_0_0);
    end
    saw_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ov8 !== 1'b0) saw_valid = 1'b1;
    end
    vectors++;
    if (saw_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_no_valid: got out_valid=1 expected 0");
    end
    model_scan(32'h90, 1'b1, ecnt, ehit);
    do_word(32'h90, 1'b1, 0, lat, cnt, any, hit);
    vectors++;
    if ({cnt, any, hit} !== {4'd1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_next_word: got cnt=%0d any=%b hit=%b expected 1 1 0", cnt, any, hit);
    end
  endtask

  task automatic test_random();
    int lat;
    int w;
    logic [31:0] data;
    logic c;
    logic [3:0] cnt, ecnt;
    logic any, hit, ehit;
    for (int i = 0; i < 48; i++) begin
      sel  = (i >= 40);
      w    = sel ? 32 : 8;
      data = $urandom;
      if (!sel) data = {24'h0, data[7:0]};
      c    = 1'($urandom_range(0, 1));
      model_scan(data, c, ecnt, ehit);
      do_word(data, c, $urandom_range(0, 3), lat, cnt, any, hit);
      vectors++;
      if (lat != w || cnt !== ecnt || any !== (ecnt != 4'd0) || hit !== ehit) begin
        miscompares++;
        $display("FAIL random%0d data=%h carry=%b: got lat=%0d cnt=%0d any=%b hit=%b expected lat=%0d cnt=%0d any=%b hit=%b",
                 i, data, c, lat, cnt, any, hit, w, ecnt, (ecnt != 4'd0), ehit);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    sel       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    carry     = 1'b0;
    out_ready = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_non_overlap();
    test_carry();
    test_saturation();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq1001_scan_ctrl.md
# seq1001_scan_ctrl

Word-level controller for the non-overlapping Moore "1001" detector. It accepts a parallel word through a valid/ready handshake and serializes it MSB-first into an embedded 5-state Moore detector, one bit per cycle. It counts completed "1001" detections in that word and presents the saturating count through a second valid/ready handshake. The block sits between a word-oriented producer and any consumer of per-word match statistics.

## Interface
- WIDTH, 8: bits per input word; must be ≥ 1.
- CNT_W, 4: width of the match counter; must be ≥ 1.

- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  word to scan; bit WIDTH-1 is fed first.
- carry  input  1  sampled with the word. 1 keeps the detector state from the previous word. 0 restarts the detector at S0.
- out_valid  output  1  match_cnt and match_any are valid.
- out_ready  input  1  consumer accepts the result.
- match_cnt  output  CNT_W  number of detections in the last word, saturating.
- match_any  output  1  match_cnt != 0.
- busy  output  1  controller is not in IDLE.
- det_hit  output  1  Moore detector output: 1 exactly when the detector is in S4.

## Operation
- Controller FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - load the shift register with in_data
    - set the bit counter to WIDTH-1
    - clear the count
    - if carry=0, force the detector to S0
    - go to SHIFT.
  - SHIFT: each cycle, feed shift-register MSB to the detector, shift left, decrement the bit counter. When the counter is 0, this is the last bit; go to REPORT.
  - REPORT: out_valid=1. match_cnt and match_any are held stable. On out_ready, go to IDLE.
- Detector state transitions (bit 1 / bit 0):
  - S0: 1→S1, 0→S0
  - S1: 1→S1, 0→S2
  - S2: 1→S1, 0→S3
  - S3: 1→S4, 0→S0
  - S4: 1→S1, 0→S0
- S4 does not chain, so detection is non-overlapping. The detector state advances only in SHIFT and is held in IDLE and REPORT.
- Counting:
  - The count increments at the same edge where a fed bit moves the detector into S4.
  - A detection on the last bit of a word is therefore included in that word's count.
  - The count saturates at 2^CNT_W-1 and never wraps.
- With carry=1, a pattern may span a word boundary. The detection is credited to the word containing the final '1'.
- Reset values: state=IDLE, detector=S0, count=0, shift register=0. So in_ready=1, out_valid=0, match_cnt=0, match_any=0, busy=0, det_hit=0.
- Reset asserted mid-SHIFT or mid-REPORT aborts the word. The result is discarded and out_valid is never raised for it.

## Timing
- Input handshake completes at edge E0. Bits are fed at edges E1..E_WIDTH. out_valid rises after E_WIDTH and stays high until out_valid&&out_ready.
- The earliest next acceptance is one cycle after the result handshake. Minimum period is WIDTH+2 cycles per word.
- in_ready=0 in SHIFT and REPORT; in_data is ignored there.
- out_valid must not depend combinationally on out_ready. in_ready must not depend on in_valid. Both are pure state decodes.
- det_hit is registered-state Moore: it is high for the cycle after the edge that entered S4. If the word ends there, det_hit stays high through REPORT.
- busy=1 from the cycle after E0 through the cycle the result is accepted.

## Test plan
- Reset, then in_data=8'b1001_1001, carry=0, out_ready=1 → out_valid rises 8 cycles after acceptance, match_cnt=2, match_any=1, det_hit=1 in REPORT.
- Non-overlap check: 8'b1001_0010, carry=0 → match_cnt=1, not 2. Final detector state is S2 and det_hit=0.
- Carry across words:
  - word A=8'b0000_0100 (carry=0, count 0, ends in S3), then word B=8'b1000_0000 with carry=1 → B count=1.
  - repeat with carry=0 on B → B count=0.
- Saturation with WIDTH=32, CNT_W=2: in_data=32'h9999_9999 → 8 detections, match_cnt=3 (saturated), match_any=1.
- Backpressure: hold out_ready=0 for 5 cycles in REPORT → out_valid, match_cnt and det_hit stay stable, in_ready=0, and a pending in_valid is not accepted. Raise out_ready → IDLE next cycle, then the word is accepted.
- Assert rst for one cycle at the 4th SHIFT cycle → next cycle all outputs at reset values, no out_valid for that word. The next word 8'h90 scans from S0 and gives match_cnt=1.
